// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Owns the fetch PC and issues pipelined requests to an instruction memory
//   that may insert wait states. In-order responses are tagged with their PC
//   and held in a DEPTH-entry queue, which feeds decode over valid/ready. A
//   redirect flushes the queue, restarts fetch at redirectAddr and discards
//   the responses that are still in flight.
//
//   Optional feature (macro FETCH_BYPASS_EN): when the queue is empty, a
//   non-dropped response is presented to decode in the same cycle. If decode
//   consumes it in that cycle, it is not stored.
//
// Ports:
//   clk, rstN                 clock (rising edge), async active-low reset
//   memReqValid/Ready/Addr    request channel to instruction memory
//   memRespValid/Data         in-order response channel (never back-pressured)
//   redirect, redirectAddr    flush and restart fetch at a new PC
//   instValid/Ready           instruction handshake to decode
//   instruction, instPc       head instruction and its PC (0 when empty)
//   occupancy                 number of queue entries held
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    output logic                     memReqValid,
    input  logic                     memReqReady,
    output logic [ADDR_W-1:0]        memReqAddr,
    input  logic                     memRespValid,
    input  logic [DATA_W-1:0]        memRespData,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirectAddr,
    output logic                     instValid,
    input  logic                     instReady,
    output logic [DATA_W-1:0]        instruction,
    output logic [ADDR_W-1:0]        instPc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Requests issued after a redirect are credited against live entries only,
    // so stale in-flight requests can pile up on top of DEPTH while a slow
    // memory drains them. Two extra bits cover several back-to-back redirects
    // against a stalled memory.
    localparam int OUT_W = CNT_W + 2;
    localparam int SUM_W = OUT_W + 1;

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] respPc;
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  dropCount;
    // Keeps memReqValid low while in reset and for the first cycle after it.
    logic              fetchEn;

    logic [SUM_W-1:0]  inUse;
    logic              reqFire;
    logic              respDrop;
    logic              respPush;
    logic              qValid;
    logic              qPop;
    logic              store;
    logic [OUT_W-1:0]  outAfter;

    // Live entries plus live (non-dropped) in-flight requests.
    assign inUse = SUM_W'(count) + SUM_W'(outstanding) - SUM_W'(dropCount);

    assign memReqValid = fetchEn && !redirect && (inUse < SUM_W'(DEPTH));
    assign memReqAddr  = fetchPc;
    assign reqFire     = memReqValid && memReqReady;

    assign respDrop    = memRespValid && (dropCount != '0);
    assign respPush    = memRespValid && (dropCount == '0);

    assign qValid      = (count != '0);
    // A pop coinciding with a redirect is ignored: the flush wins.
    assign qPop        = qValid && instReady && !redirect;
    assign occupancy   = count;

    assign outAfter    = outstanding + OUT_W'(reqFire) - OUT_W'(memRespValid);

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass = respPush && !qValid && !redirect;
    // A bypassed word taken by decode in the same cycle never enters the queue.
    assign store  = respPush && !(bypass && instReady);
`else
    assign store  = respPush;
`endif

    always_comb begin
        instValid   = qValid;
        instruction = '0;
        instPc      = '0;
        if (qValid) begin
            instruction = dataMem[rdPtr];
            instPc      = pcMem[rdPtr];
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass) begin
            instValid   = 1'b1;
            instruction = memRespData;
            instPc      = respPc;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetchEn     <= 1'b0;
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            outstanding <= '0;
            dropCount   <= '0;
        end else begin
            fetchEn     <= 1'b1;
            outstanding <= outAfter;
            if (redirect) begin
                fetchPc   <= redirectAddr;
                respPc    <= redirectAddr;
                wrPtr     <= '0;
                rdPtr     <= '0;
                count     <= '0;
                // Everything still in flight is stale; set, never accumulate.
                dropCount <= outAfter;
            end else begin
                if (reqFire)  fetchPc   <= fetchPc + PC_STEP;
                if (respPush) respPc    <= respPc + PC_STEP;
                if (respDrop) dropCount <= dropCount - OUT_W'(1);
                if (store)    wrPtr     <= wrPtr + PTR_W'(1);
                if (qPop)     rdPtr     <= rdPtr + PTR_W'(1);
                count <= count + CNT_W'(store) - CNT_W'(qPop);
            end
        end
    end

    // NOTE: the queue storage has no reset; every read is qualified by
    // count != 0, so contents left over from before reset or a flush are
    // never visible.
    always_ff @(posedge clk) begin
        if (store) begin
            dataMem[wrPtr] <= memRespData;
            pcMem[wrPtr]   <= respPc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        memReqValid;
    logic        memReqReady = 1'b0;
    logic [31:0] memReqAddr;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespData = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirectAddr = '0;
    logic        instValid;
    logic        instReady = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instPc;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk          (clk),
        .rstN         (rstN),
        .memReqValid  (memReqValid),
        .memReqReady  (memReqReady),
        .memReqAddr   (memReqAddr),
        .memRespValid (memRespValid),
        .memRespData  (memRespData),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .instValid    (instValid),
        .instReady    (instReady),
        .instruction  (instruction),
        .instPc       (instPc),
        .occupancy    (occupancy)
    );

    int total = 0;
    int bad   = 0;

    // Memory model: accepted addresses wait in pend, answered one per cycle
    // starting the cycle after acceptance; data = 0x1000 + addr/4.
    logic [31:0] pend[$];
    logic [31:0] reqLog[$];
    logic [31:0] gotPc[$];
    logic [31:0] gotInst[$];
    bit          memHold = 1'b0;
    bit          useOverride = 1'b0;
    logic [31:0] overrideData = '0;

    logic        sReqValid, sInstValid;
    logic [31:0] sReqAddr, sInst, sInstPc;
    logic [2:0]  sOcc;

    // One clock cycle: present memory response, settle, sample, log handshakes.
    task automatic cycle();
        if (!memHold && pend.size() != 0) begin
            memRespValid = 1'b1;
            memRespData  = useOverride ? overrideData : 32'h1000 + (pend[0] >> 2);
        end else begin
            memRespValid = 1'b0;
            memRespData  = '0;
        end
        #1;
        sReqValid  = memReqValid;
        sReqAddr   = memReqAddr;
        sInstValid = instValid;
        sInst      = instruction;
        sInstPc    = instPc;
        sOcc       = occupancy;
        if (memReqValid && memReqReady) begin
            pend.push_back(memReqAddr);
            reqLog.push_back(memReqAddr);
        end
        if (memRespValid) void'(pend.pop_front());
        if (instValid && instReady && !redirect) begin
            gotPc.push_back(instPc);
            gotInst.push_back(instruction);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        memReqReady = 1'b0; instReady = 1'b0; redirect = 1'b0; redirectAddr = '0;
        memRespValid = 1'b0; memRespData = '0; memHold = 1'b0; useOverride = 1'b0;
        pend.delete(); reqLog.delete(); gotPc.delete(); gotInst.delete();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        #2;
        total++; if (memReqValid !== 1'b0) begin bad++; $display("FAIL rst_reqValid got=%0h want=0", memReqValid); end
        total++; if (instValid !== 1'b0) begin bad++; $display("FAIL rst_instValid got=%0h want=0", instValid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occupancy got=%0d want=0", occupancy); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instruction got=%0h want=0", instruction); end
        total++; if (instPc !== 32'h0) begin bad++; $display("FAIL rst_instPc got=%0h want=0", instPc); end
        total++; if (memReqAddr !== 32'h0) begin bad++; $display("FAIL rst_reqAddr got=%0h want=0", memReqAddr); end
        // Fill partially, then reset mid-operation.
        doReset();
        memReqReady = 1'b1;
        repeat (4) cycle();
        #2;
        rstN = 1'b0;
        #1;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL midrst_occupancy got=%0d want=0", occupancy); end
        total++; if (instValid !== 1'b0) begin bad++; $display("FAIL midrst_instValid got=%0h want=0", instValid); end
        total++; if (memReqValid !== 1'b0) begin bad++; $display("FAIL midrst_reqValid got=%0h want=0", memReqValid); end
        total++; if (memReqAddr !== 32'h0) begin bad++; $display("FAIL midrst_reqAddr got=%0h want=0", memReqAddr); end
    endtask

    task automatic test_stream();
        doReset();
        memReqReady = 1'b1; instReady = 1'b1;
        repeat (10) cycle();
        total++; if (reqLog.size() != 10) begin bad++; $display("FAIL stream_reqCount got=%0d want=10", reqLog.size()); end
        total++; if (gotPc.size() != 8) begin bad++; $display("FAIL stream_popCount got=%0d want=8", gotPc.size()); end
        for (int i = 0; i < reqLog.size(); i++) begin
            total++; if (reqLog[i] !== 32'(4 * i)) begin bad++; $display("FAIL stream_reqAddr[%0d] got=%0h want=%0h", i, reqLog[i], 4 * i); end
        end
        for (int i = 0; i < gotPc.size(); i++) begin
            total++;
            if (gotPc[i] !== 32'(4 * i) || gotInst[i] !== 32'(32'h1000 + i)) begin
                bad++; $display("FAIL stream_inst[%0d] got=%0h/%0h want=%0h/%0h", i, gotPc[i], gotInst[i], 4 * i, 32'h1000 + i);
            end
        end
    endtask

    task automatic test_full();
        doReset();
        memReqReady = 1'b1; instReady = 1'b0;
        repeat (10) cycle();
        total++; if (reqLog.size() != 4) begin bad++; $display("FAIL full_reqCount got=%0d want=4", reqLog.size()); end
        total++; if (sReqValid !== 1'b0) begin bad++; $display("FAIL full_reqValid got=%0h want=0", sReqValid); end
        total++; if (sOcc !== 3'd4) begin bad++; $display("FAIL full_occupancy got=%0d want=4", sOcc); end
        instReady = 1'b1;
        repeat (10) cycle();
        total++; if (gotPc.size() != 10) begin bad++; $display("FAIL full_popCount got=%0d want=10", gotPc.size()); end
        total++; if (reqLog.size() != 13) begin bad++; $display("FAIL full_reqCount2 got=%0d want=13", reqLog.size()); end
        for (int i = 0; i < gotPc.size(); i++) begin
            total++;
            if (gotPc[i] !== 32'(4 * i) || gotInst[i] !== 32'(32'h1000 + i)) begin
                bad++; $display("FAIL full_inst[%0d] got=%0h/%0h want=%0h/%0h", i, gotPc[i], gotInst[i], 4 * i, 32'h1000 + i);
            end
        end
    endtask

    task automatic test_stall();
        logic        prevStall;
        logic [31:0] prevAddr;
        doReset();
        instReady = 1'b1;
        prevStall = 1'b0;
        prevAddr  = '0;
        for (int k = 0; k < 24; k++) begin
            memReqReady = (k % 3 == 0);
            cycle();
            if (prevStall) begin
                total++; if (sReqAddr !== prevAddr) begin bad++; $display("FAIL stall_hold k=%0d got=%0h want=%0h", k, sReqAddr, prevAddr); end
            end
            prevStall = sReqValid && !memReqReady;
            prevAddr  = sReqAddr;
        end
        total++; if (reqLog.size() != 8) begin bad++; $display("FAIL stall_reqCount got=%0d want=8", reqLog.size()); end
        total++; if (gotPc.size() != 8) begin bad++; $display("FAIL stall_popCount got=%0d want=8", gotPc.size()); end
        for (int i = 0; i < reqLog.size(); i++) begin
            total++; if (reqLog[i] !== 32'(4 * i)) begin bad++; $display("FAIL stall_reqAddr[%0d] got=%0h want=%0h", i, reqLog[i], 4 * i); end
        end
        for (int i = 0; i < gotPc.size(); i++) begin
            total++; if (gotPc[i] !== 32'(4 * i)) begin bad++; $display("FAIL stall_instPc[%0d] got=%0h want=%0h", i, gotPc[i], 4 * i); end
        end
    endtask

    task automatic test_redirect();
        doReset();
        memReqReady = 1'b1; instReady = 1'b0;
        repeat (3) cycle();
        memHold = 1'b1;
        cycle();                                   // two requests now in flight
        redirect = 1'b1; redirectAddr = 32'h300;
        cycle();
        total++; if (sReqValid !== 1'b0) begin bad++; $display("FAIL redir_reqValid got=%0h want=0", sReqValid); end
        redirectAddr = 32'h400;                    // back-to-back redirect
        cycle();
        total++; if (sOcc !== 3'd0) begin bad++; $display("FAIL redir_flush1 got=%0d want=0", sOcc); end
        redirect = 1'b0; memHold = 1'b0; instReady = 1'b1;
        cycle();
        total++; if (sOcc !== 3'd0) begin bad++; $display("FAIL redir_occupancy got=%0d want=0", sOcc); end
        total++; if (sInstValid !== 1'b0) begin bad++; $display("FAIL redir_instValid got=%0h want=0", sInstValid); end
        total++; if (sReqAddr !== 32'h400) begin bad++; $display("FAIL redir_reqAddr got=%0h want=400", sReqAddr); end
        repeat (6) cycle();
        total++; if (gotPc.size() != 4) begin bad++; $display("FAIL redir_popCount got=%0d want=4", gotPc.size()); end
        total++;
        if (gotPc.size() < 2 || gotPc[0] !== 32'h400 || gotInst[0] !== 32'h1100 || gotPc[1] !== 32'h404) begin
            bad++; $display("FAIL redir_first got=%0h/%0h want=400/1100", gotPc.size() > 0 ? gotPc[0] : 32'hx, gotInst.size() > 0 ? gotInst[0] : 32'hx);
        end
    endtask

    task automatic test_double_redirect();
        doReset();
        memReqReady = 1'b1; instReady = 1'b1;
        repeat (4) cycle();
        redirect = 1'b1; redirectAddr = 32'h200;   // response and pop coincide
        cycle();
        total++; if (!(sInstValid === 1'b1 && memRespValid === 1'b1)) begin bad++; $display("FAIL dbl_setup got=%0h want=1", sInstValid); end
        gotPc.delete(); gotInst.delete();
        redirect = 1'b0;
        cycle();
        total++; if (sInstValid !== 1'b0) begin bad++; $display("FAIL dbl_flush got=%0h want=0", sInstValid); end
        redirect = 1'b1; redirectAddr = 32'h800;
        cycle();
        redirect = 1'b0;
        repeat (8) cycle();
        total++; if (gotPc.size() != 6) begin bad++; $display("FAIL dbl_popCount got=%0d want=6", gotPc.size()); end
        for (int i = 0; i < gotPc.size(); i++) begin
            total++;
            if (gotPc[i] !== 32'(32'h800 + 4 * i) || gotInst[i] !== 32'(32'h1200 + i)) begin
                bad++; $display("FAIL dbl_inst[%0d] got=%0h/%0h want=%0h/%0h", i, gotPc[i], gotInst[i], 32'h800 + 4 * i, 32'h1200 + i);
            end
        end
    endtask

    task automatic test_latency();
        doReset();
        useOverride = 1'b1; overrideData = 32'hDEAD;
        redirect = 1'b1; redirectAddr = 32'h10;
        cycle();
        redirect = 1'b0; memReqReady = 1'b1;
        cycle();
        total++; if (sReqAddr !== 32'h10) begin bad++; $display("FAIL lat_reqAddr got=%0h want=10", sReqAddr); end
        memReqReady = 1'b0;
        cycle();                                   // response cycle
`ifdef FETCH_BYPASS_EN
        total++;
        if (sInstValid !== 1'b1 || sInst !== 32'hDEAD || sInstPc !== 32'h10) begin
            bad++; $display("FAIL lat_bypass got=%0h/%0h/%0h want=1/dead/10", sInstValid, sInst, sInstPc);
        end
`else
        total++; if (sInstValid !== 1'b0) begin bad++; $display("FAIL lat_sameCycle got=%0h want=0", sInstValid); end
`endif
        cycle();
        total++;
        if (sInstValid !== 1'b1 || sInst !== 32'hDEAD || sInstPc !== 32'h10) begin
            bad++; $display("FAIL lat_next got=%0h/%0h/%0h want=1/dead/10", sInstValid, sInst, sInstPc);
        end
        total++; if (sOcc !== 3'd1) begin bad++; $display("FAIL lat_occupancy got=%0d want=1", sOcc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_stall();
        test_redirect();
        test_double_redirect();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
